// File: rtl/booth_wallace_mul_24x24_pkg.sv
// Shared sizes, Booth select encoding and the radix-4 recoding function
// for the 24x24 Booth/Wallace multiplier.
package booth_mul_pkg;

  localparam int WIDTH  = 24;
  localparam int PP_W   = 26;
  localparam int NUM_PP = 13;
  localparam int PROD_W = 48;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_sel_e;

  // grp = {B[2i+1], B[2i], B[2i-1]}
  function automatic booth_sel_e booth_sel(input logic [2:0] grp);
    booth_sel_e sel;
    case (grp)
      3'b000, 3'b111: sel = ZERO;
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_wallace_mul_24x24_if.sv
// Operand/result bundle for booth_wallace_mul_24x24; master drives operands,
// slave (the multiplier) returns the product.
interface booth_wallace_mul_24x24_if;
  import booth_mul_pkg::*;

  logic              in_valid;
  logic              a_signed;
  logic              b_signed;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              out_valid;
  logic [PROD_W-1:0] prod;

  modport master (
    output in_valid, a_signed, b_signed, a, b,
    input  out_valid, prod
  );

  modport slave (
    input  in_valid, a_signed, b_signed, a, b,
    output out_valid, prod
  );
endinterface

// File: rtl/booth_wallace_mul_24x24_csa_3_2.sv
// Bit-parallel 3:2 carry-save compressor; carry is pre-shifted to its weight
// and the bit pushed past the top is dropped (modulo 2^W arithmetic).
module csa_3_2 #(
  parameter int W = 48
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = x ^ y ^ z;
  assign carry = ((x & y) | (x & z) | (y & z)) << 1;

endmodule

// File: rtl/booth_wallace_mul_24x24.sv
// Radix-4 Booth, Wallace-tree 24x24 multiplier with a 48-bit product.
// Define BWM_MID_REG_EN to register the Wallace sum/carry (latency 2); otherwise latency 1.
module booth_wallace_mul_24x24
  import booth_mul_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  booth_wallace_mul_24x24_if.slave  bus
);

  logic [PP_W-1:0]   a_ext;
  logic [PP_W:0]     b_ext;
  logic [PROD_W-1:0] row [NUM_PP];
  logic [NUM_PP-2:0] neg;

  assign a_ext = {{2{bus.a_signed & bus.a[WIDTH-1]}}, bus.a};
  // b_ext[0] is the implicit B[-1]=0, so group i sits at b_ext[2i+2:2i]
  assign b_ext = {{2{bus.b_signed & bus.b[WIDTH-1]}}, bus.b, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PP; gi++) begin : g_pp
      booth_sel_e        sel;
      logic [PP_W-1:0]   a_dbl;
      logic [PP_W-1:0]   pp;
      logic [PROD_W-1:0] pp_row;

      assign sel   = booth_sel(b_ext[2*gi+2 -: 3]);
      assign a_dbl = {a_ext[PP_W-2:0], 1'b0};

      always_comb begin
        pp = '0;
        case (sel)
          POS1:    pp = a_ext;
          POS2:    pp = a_dbl;
          NEG1:    pp = ~a_ext;
          NEG2:    pp = ~a_dbl;
          default: pp = '0;
        endcase
      end

      assign pp_row = {{(PROD_W-PP_W){pp[PP_W-1]}}, pp} << (2*gi);

      // Row gi is zero below column 2gi, so neg of group gi-1 fits in there.
      if (gi == 0) begin : g_first
        assign row[gi] = pp_row;
      end else begin : g_rest
        assign row[gi] = pp_row | ({{(PROD_W-1){1'b0}}, neg[gi-1]} << (2*(gi-1)));
      end

      // The top group is {ext, ext, b[23]}: never 100/101/110, so it never negates.
      if (gi < NUM_PP-1) begin : g_neg
        assign neg[gi] = (sel == NEG1) || (sel == NEG2);
      end
    end
  endgenerate

  logic [PROD_W-1:0] l1 [9];
  logic [PROD_W-1:0] l2 [6];
  logic [PROD_W-1:0] l3 [4];
  logic [PROD_W-1:0] l4 [3];
  logic [PROD_W-1:0] wal_sum;
  logic [PROD_W-1:0] wal_carry;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_lvl1
      csa_3_2 #(.W(PROD_W)) u_csa (
        .x(row[3*gi]), .y(row[3*gi+1]), .z(row[3*gi+2]),
        .sum(l1[2*gi]), .carry(l1[2*gi+1])
      );
    end
    for (gi = 0; gi < 3; gi++) begin : g_lvl2
      csa_3_2 #(.W(PROD_W)) u_csa (
        .x(l1[3*gi]), .y(l1[3*gi+1]), .z(l1[3*gi+2]),
        .sum(l2[2*gi]), .carry(l2[2*gi+1])
      );
    end
    for (gi = 0; gi < 2; gi++) begin : g_lvl3
      csa_3_2 #(.W(PROD_W)) u_csa (
        .x(l2[3*gi]), .y(l2[3*gi+1]), .z(l2[3*gi+2]),
        .sum(l3[2*gi]), .carry(l3[2*gi+1])
      );
    end
  endgenerate

  assign l1[8] = row[NUM_PP-1];
  assign l4[2] = l3[3];

  csa_3_2 #(.W(PROD_W)) u_csa_lvl4 (
    .x(l3[0]), .y(l3[1]), .z(l3[2]),
    .sum(l4[0]), .carry(l4[1])
  );

  csa_3_2 #(.W(PROD_W)) u_csa_lvl5 (
    .x(l4[0]), .y(l4[1]), .z(l4[2]),
    .sum(wal_sum), .carry(wal_carry)
  );

  logic [PROD_W-1:0] prod_q, prod_d;
  logic              out_valid_q, out_valid_d;

`ifdef BWM_MID_REG_EN
  logic [PROD_W-1:0] sum_q, sum_d;
  logic [PROD_W-1:0] carry_q, carry_d;
  logic              mid_valid_q, mid_valid_d;

  always_comb begin
    sum_d       = wal_sum;
    carry_d     = wal_carry;
    mid_valid_d = bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q       <= '0;
      carry_q     <= '0;
      mid_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      mid_valid_q <= mid_valid_d;
    end
  end

  always_comb begin
    prod_d      = sum_q + carry_q;
    out_valid_d = mid_valid_q;
  end
`else
  always_comb begin
    prod_d      = wal_sum + wal_carry;
    out_valid_d = bus.in_valid;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      prod_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.prod      = prod_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_booth_wallace_mul_24x24.sv
// Self-checking bench for booth_wallace_mul_24x24: directed corners, random
// streams against an integer reference model, and reset behaviour.
module tb_booth_wallace_mul_24x24;

`ifdef BWM_MID_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  booth_wallace_mul_24x24_if bus ();

  booth_wallace_mul_24x24 dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret each operand as a plain integer, multiply, keep 48 bits.
  function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b,
                                          input logic as, input logic bs);
    longint av;
    longint bv;
    longint p;
    av = longint'(a);
    bv = longint'(b);
    if (as && a[23]) av = av - (longint'(1) << 24);
    if (bs && b[23]) bv = bv - (longint'(1) << 24);
    p = av * bv;
    return p[47:0];
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_signed = 1'b0;
    bus.b_signed = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.prod !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_prod: got %h expected 000000000000", bus.prod);
    end
    rst = 1'b1;
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [23:0] ta [5];
    logic [23:0] tb [5];
    logic        tas [5];
    logic        tbs [5];
    logic [47:0] texp [5];
    ta[0] = 24'd136;     tb[0] = 24'd136;     tas[0] = 0; tbs[0] = 0; texp[0] = 48'h000000004840;
    ta[1] = 24'hFFFFFF;  tb[1] = 24'hFFFFFF;  tas[1] = 0; tbs[1] = 0; texp[1] = 48'hFFFFFE000001;
    ta[2] = 24'hFFFFFF;  tb[2] = 24'hFFFFFF;  tas[2] = 1; tbs[2] = 1; texp[2] = 48'h000000000001;
    ta[3] = 24'h800000;  tb[3] = 24'h800000;  tas[3] = 1; tbs[3] = 1; texp[3] = 48'h400000000000;
    ta[4] = 24'hFFFFFF;  tb[4] = 24'hFFFFFF;  tas[4] = 1; tbs[4] = 0; texp[4] = 48'hFFFFFF000001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.a = ta[i];
      bus.b = tb[i];
      bus.a_signed = tas[i];
      bus.b_signed = tbs[i];
      bus.in_valid = 1'b1;
      for (int c = 1; c <= LAT; c++) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== (c == LAT)) begin
          n_fail++;
          $display("FAIL directed%0d_valid_c%0d: got %b expected %b", i, c, bus.out_valid, (c == LAT));
        end
      end
      n_checks++;
      if (bus.prod !== texp[i]) begin
        n_fail++;
        $display("FAIL directed%0d_prod: got %h expected %h", i, bus.prod, texp[i]);
      end
      $display("directed %0d: a=%h(%0d) b=%h(%0d) prod=%h", i, ta[i], tas[i], tb[i], tbs[i], bus.prod);
    end
  endtask

  task automatic test_stream(input int n, input bit gaps, input string tag);
    logic [47:0] exp_arr [64];
    bit          v_arr [64];
    logic [31:0] r;
    for (int t = 0; t < n + LAT; t++) begin
      @(negedge clk);
      if (t >= LAT) begin
        n_checks++;
        if (bus.out_valid !== v_arr[t-LAT]) begin
          n_fail++;
          $display("FAIL %s_valid_t%0d: got %b expected %b", tag, t, bus.out_valid, v_arr[t-LAT]);
        end else if (v_arr[t-LAT]) begin
          n_checks++;
          if (bus.prod !== exp_arr[t-LAT]) begin
            n_fail++;
            $display("FAIL %s_prod_t%0d: got %h expected %h", tag, t, bus.prod, exp_arr[t-LAT]);
          end
          $display("%s result %0d: prod=%h", tag, t - LAT, bus.prod);
        end
      end else begin
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_idle_t%0d: got %b expected 0", tag, t, bus.out_valid);
        end
      end
      if (t < n) begin
        r = $urandom;
        bus.a = r[23:0];
        r = $urandom;
        bus.b = r[23:0];
        r = $urandom;
        bus.a_signed = r[0];
        bus.b_signed = r[1];
        v_arr[t] = gaps ? r[2] : 1'b1;
        bus.in_valid = v_arr[t];
        exp_arr[t] = ref_mul(bus.a, bus.b, bus.a_signed, bus.b_signed);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.a = 24'h123456;
    bus.b = 24'h654321;
    bus.a_signed = 1'b0;
    bus.b_signed = 1'b1;
    bus.in_valid = 1'b1;
    for (int c = 1; c < LAT; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midflight_pre_valid: got %b expected 0", bus.out_valid);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_rst_valid: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.prod !== 48'h0) begin
      n_fail++;
      $display("FAIL midflight_rst_prod: got %h expected 000000000000", bus.prod);
    end
    rst = 1'b1;
    for (int c = 0; c <= LAT; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midflight_post_valid_c%0d: got %b expected 0", c, bus.out_valid);
      end
    end
    $display("reset midflight: in-flight operation dropped, out_valid=%b", bus.out_valid);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    test_reset();
    test_directed();
    test_stream(4, 1'b0, "back_to_back");
    test_stream(40, 1'b0, "stream");
    test_stream(40, 1'b1, "gaps");
    test_reset_midflight();
    test_stream(8, 1'b0, "after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
